// File: rtl/i2c_fifo_pkg.sv
// i2c_fifo_pkg
//   Shared definitions for the I2C transmit FIFO read-side logic:
//   read sequencer state encoding and default data/length widths.
package i2c_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_LEN_WIDTH  = 8;

  // Read sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } rd_state_e;

endpackage

// File: rtl/fifo_wait_timer.sv
// fifo_wait_timer
//   Counts consecutive cycles spent waiting on an empty FIFO and flags
//   expiry once the count has reached TIMEOUT. The count saturates there.
// Ports:
//   clk_i  - read-domain clock
//   rst_i  - synchronous active-high reset
//   clear  - return the count to zero (takes priority over enable)
//   enable - advance the count by one this cycle
//   expire - count has reached TIMEOUT
module fifo_wait_timer #(
  parameter int TIMEOUT = 255,
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [CW-1:0] count;

  assign expire = (count == CW'(TIMEOUT));

  // Wait counter; holds at TIMEOUT so expire stays asserted until cleared
  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/i2c_tx_fifo_rd_ctrl.sv
// i2c_tx_fifo_rd_ctrl
//   Read-side sequencer for the I2C transmit async FIFO. Pops a programmed
//   number of bytes from the show-ahead FIFO and presents them to the byte
//   shifter over valid/ready, reporting completion, underrun and count.
// Ports:
//   clk_i, rst_i          - read-domain clock, synchronous active-high reset
//   start_i, len_i        - begin a transfer of len_i bytes (IDLE only)
//   abort_i               - terminate the current transfer
//   rempty_i, rdata_i     - FIFO empty flag and show-ahead head data
//   rinc_o                - FIFO pop strobe (combinational)
//   tx_valid_o, tx_data_o - registered byte to the shifter
//   tx_ready_i            - shifter accepts the byte
//   busy_o                - transfer in progress (not IDLE)
//   done_o, underrun_o    - completion pulse, underrun flag on that pulse
//   sent_cnt_o            - bytes handshaken in current/last transfer
module i2c_tx_fifo_rd_ctrl
  import i2c_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEFAULT_LEN_WIDTH,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic                  abort_i,
  input  logic                  rempty_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic                  rinc_o,
  output logic                  tx_valid_o,
  output logic [DATA_WIDTH-1:0] tx_data_o,
  input  logic                  tx_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  underrun_o,
  output logic [LEN_WIDTH-1:0]  sent_cnt_o
);

  rd_state_e            state;
  logic [LEN_WIDTH-1:0] remaining;
  logic                 timer_enable;
  logic                 timer_clear;
  logic                 timer_expire;

  // A pop is only legal with data present and no abort pending. In HOLD the
  // next byte is fetched in the same cycle as the handshake to sustain one
  // byte per cycle, but only while bytes remain to be fetched.
  assign rinc_o = !rempty_i && !abort_i &&
                  ((state == LOAD) ||
                   ((state == HOLD) && tx_ready_i && (remaining != '0)));

  assign busy_o = (state != IDLE);

  // The timer only runs while starving in LOAD; any other cycle restarts it
  assign timer_enable = (state == LOAD) && rempty_i && !abort_i;
  assign timer_clear  = !timer_enable;

  generate
    if (TIMEOUT != 0) begin : g_timer
      fifo_wait_timer #(
        .TIMEOUT (TIMEOUT)
      ) u_wait_timer (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expire (timer_expire)
      );
    end else begin : g_no_timer
      assign timer_expire = 1'b0;
    end
  endgenerate

  // Sequencer FSM with registered outputs. done_o/underrun_o are set on the
  // transition into DONE so they are high exactly while the FSM sits there.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      remaining  <= '0;
      sent_cnt_o <= '0;
      tx_valid_o <= 1'b0;
      tx_data_o  <= '0;
      done_o     <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      done_o     <= 1'b0;
      underrun_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            remaining  <= len_i;
            sent_cnt_o <= '0;
            if (len_i == '0) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (abort_i) begin
            state      <= DONE;
            done_o     <= 1'b1;
            tx_valid_o <= 1'b0;
          end else if (!rempty_i) begin
            tx_data_o  <= rdata_i;
            tx_valid_o <= 1'b1;
            remaining  <= remaining - LEN_WIDTH'(1);
            state      <= HOLD;
          end else if (timer_expire) begin
            state      <= DONE;
            done_o     <= 1'b1;
            underrun_o <= 1'b1;
          end
        end
        HOLD: begin
          // A handshake coinciding with abort still counts
          if (tx_ready_i) begin
            sent_cnt_o <= sent_cnt_o + LEN_WIDTH'(1);
          end
          if (abort_i) begin
            state      <= DONE;
            done_o     <= 1'b1;
            tx_valid_o <= 1'b0;
          end else if (tx_ready_i) begin
            if (remaining == '0) begin
              state      <= DONE;
              done_o     <= 1'b1;
              tx_valid_o <= 1'b0;
            end else if (!rempty_i) begin
              tx_data_o <= rdata_i;
              remaining <= remaining - LEN_WIDTH'(1);
            end else begin
              tx_valid_o <= 1'b0;
              state      <= LOAD;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
